zacapa_word_matcher: RTL

Receiving end of the character-stream generator: consumes an 8-bit ASCII byte stream and recognises the two fixed words the generator emits, "Guatemala" or "QQuetza", chosen by `select`. It tracks match progress with an overlap-correct state machine, pulses on every complete word, counts words and broken sequences, and reports lock once the stream repeats cleanly. It sits on the loopback/test path next to the generator, fed from its `q_out`.

---
 rtl/zacapa_word_matcher.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/zacapa_word_matcher.sv
// Recognises "Guatemala" (select class A) or "QQuetza" (class B) in an accepted byte stream, with KMP fallback on mismatch.
// Counts completed words and broken sequences, and asserts lock after two back-to-back clean matches.
module zacapa_word_matcher (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d_in,
  input  logic       valid,
  input  logic [1:0] select,
  output logic       match,
  output logic [3:0] index,
  output logic       locked,
  output logic [7:0] word_count,
  output logic [7:0] err_count
);

  logic       r_sel_b;
  logic [3:0] r_index;
  logic [1:0] r_run;
  logic       r_match;
  logic       r_locked;
  logic [7:0] r_word_cnt;
  logic [7:0] r_err_cnt;

  logic       w_sel_b;
  logic       w_sel_chg;
  logic [7:0] w_exp;
  logic       w_last;
  logic [3:0] w_fallback;
  logic [3:0] w_index_nxt;
  logic [1:0] w_run_nxt;
  logic       w_match_nxt;
  logic       w_locked_nxt;
  logic [7:0] w_word_cnt_nxt;
  logic [7:0] w_err_cnt_nxt;

  function automatic logic [7:0] word_byte(input logic sel_b, input logic [3:0] k);
    logic [7:0] b;
    b = 8'h00;
    if (sel_b) begin
      case (k)
        4'd0, 4'd1: b = 8'h51;
        4'd2:       b = 8'h75;
        4'd3:       b = 8'h65;
        4'd4:       b = 8'h74;
        4'd5:       b = 8'h7A;
        4'd6:       b = 8'h61;
        default:    b = 8'h00;
      endcase
    end else begin
      case (k)
        4'd0:       b = 8'h47;
        4'd1:       b = 8'h75;
        4'd2, 4'd6,
        4'd8:       b = 8'h61;
        4'd3:       b = 8'h74;
        4'd4:       b = 8'h65;
        4'd5:       b = 8'h6D;
        4'd7:       b = 8'h6C;
        default:    b = 8'h00;
      endcase
    end
    return b;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // 00/11 and 01/10 select the same word, so only the XOR is tracked
  assign w_sel_b   = select[0] ^ select[1];
  assign w_sel_chg = (w_sel_b != r_sel_b);
  assign w_exp     = word_byte(r_sel_b, r_index);
  assign w_last    = (r_index == (r_sel_b ? 4'd6 : 4'd8));

  always_comb begin
    w_fallback = 4'd0;
    if (!r_sel_b) begin
      if (d_in == 8'h47) w_fallback = 4'd1;
    end else if (d_in == 8'h51) begin
      if (r_index == 4'd2)      w_fallback = 4'd2;
      else if (r_index >= 4'd3) w_fallback = 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    r_sel_b <= w_sel_b;
    if (reset) begin
      r_index    <= 4'd0;
      r_run      <= 2'd0;
      r_match    <= 1'b0;
      r_locked   <= 1'b0;
      r_word_cnt <= 8'd0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_index    <= w_index_nxt;
      r_run      <= w_run_nxt;
      r_match    <= w_match_nxt;
      r_locked   <= w_locked_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_index_nxt    = r_index;
    w_run_nxt      = r_run;
    w_match_nxt    = 1'b0;
    w_locked_nxt   = r_locked;
    w_word_cnt_nxt = r_word_cnt;
    w_err_cnt_nxt  = r_err_cnt;
    if (w_sel_chg) begin
      w_index_nxt    = 4'd0;
      w_run_nxt      = 2'd0;
      w_locked_nxt   = 1'b0;
      w_word_cnt_nxt = 8'd0;
      w_err_cnt_nxt  = 8'd0;
    end else if (valid) begin
      if (d_in == w_exp) begin
        if (w_last) begin
          // run is cleared by any mismatch, so nonzero means the previous word ended cleanly
          w_match_nxt    = 1'b1;
          w_index_nxt    = 4'd0;
          w_word_cnt_nxt = sat_inc(r_word_cnt);
          w_run_nxt      = (r_run == 2'd3) ? r_run : r_run + 2'd1;
          w_locked_nxt   = (r_run != 2'd0);
        end else begin
          w_index_nxt = r_index + 4'd1;
        end
      end else begin
        w_index_nxt  = w_fallback;
        w_run_nxt    = 2'd0;
        w_locked_nxt = 1'b0;
        if (r_index != 4'd0) w_err_cnt_nxt = sat_inc(r_err_cnt);
      end
    end
  end

  always_comb begin
    match      = r_match;
    index      = r_index;
    locked     = r_locked;
    word_count = r_word_cnt;
    err_count  = r_err_cnt;
  end

endmodule
